// File: rtl/sha256_id_issuer.sv
// rtl/sha256_id_issuer.sv - packet ID allocator forking IDs to hash datapath and validator ID buffer
module sha256_id_issuer #(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sync_rst,
    input  logic [5:0] cfg_seed,
    input  logic       cfg_seed_valid,
    output logic       cfg_seed_ready,
    input  logic       pkt_req_last,
    input  logic       pkt_req_valid,
    output logic       pkt_req_ready,
    output logic [5:0] pkt_id,
    output logic       pkt_id_valid,
    input  logic       pkt_id_ready,
    output logic [5:0] id_buf_out,
    output logic       id_buf_out_last,
    output logic       id_buf_out_valid,
    input  logic       id_buf_out_ready,
    input  logic       vld_hash_valid,
    input  logic       vld_hash_ready,
    input  logic       vld_hash_err,
    output logic [6:0] status_outstanding,
    output logic [9:0] status_issue_count,
    output logic [7:0] status_err_count,
    output logic       status_underflow,
    input  logic       status_clear
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [6:0] OUT_MAX = 7'(MAX_OUTSTANDING);

    state_t     state_q, state_d;
    logic [5:0] next_id_q, next_id_d;
    logic [5:0] cur_id_q, cur_id_d;
    logic       cur_last_q, cur_last_d;
    logic [6:0] outstanding_q, outstanding_d;
    logic       pid_done_q, pid_done_d;
    logic       buf_done_q, buf_done_d;
    logic [9:0] issue_cnt_q, issue_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       underflow_q, underflow_d;

    logic seed_fire, req_fire, retire, retire_dec, pid_fire, buf_fire;

    always_comb begin
        cfg_seed_ready   = en && (state_q == IDLE) && (outstanding_q == 7'd0);
        pkt_req_ready    = en && (state_q == IDLE) && (outstanding_q < OUT_MAX) && !cfg_seed_valid;
        pkt_id_valid     = (state_q == ISSUE) && !pid_done_q;
        id_buf_out_valid = (state_q == ISSUE) && !buf_done_q;
        pkt_id           = cur_id_q;
        id_buf_out       = cur_id_q;
        id_buf_out_last  = cur_last_q;

        seed_fire  = cfg_seed_valid && cfg_seed_ready;
        req_fire   = pkt_req_valid && pkt_req_ready;
        retire     = en && vld_hash_valid && vld_hash_ready;
        retire_dec = retire && (outstanding_q != 7'd0);
        // Handshakes only count while enabled, so a frozen channel keeps its valid up.
        pid_fire   = en && pkt_id_valid && pkt_id_ready;
        buf_fire   = en && id_buf_out_valid && id_buf_out_ready;
    end

    always_comb begin
        state_d       = state_q;
        next_id_d     = next_id_q;
        cur_id_d      = cur_id_q;
        cur_last_d    = cur_last_q;
        outstanding_d = outstanding_q;
        pid_done_d    = pid_done_q;
        buf_done_d    = buf_done_q;
        issue_cnt_d   = issue_cnt_q;
        err_cnt_d     = err_cnt_q;
        underflow_d   = underflow_q;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (seed_fire) begin
                        next_id_d = cfg_seed;
                    end else if (req_fire) begin
                        cur_id_d   = next_id_q;
                        cur_last_d = pkt_req_last;
                        next_id_d  = next_id_q + 6'd1;
                        pid_done_d = 1'b0;
                        buf_done_d = 1'b0;
                        state_d    = ISSUE;
                    end
                end
                ISSUE: begin
                    pid_done_d = pid_done_q || pid_fire;
                    buf_done_d = buf_done_q || buf_fire;
                    if (pid_done_d && buf_done_d) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (req_fire && !retire_dec) begin
                outstanding_d = outstanding_q + 7'd1;
            end else if (!req_fire && retire_dec) begin
                outstanding_d = outstanding_q - 7'd1;
            end

            if (status_clear) begin
                issue_cnt_d = 10'd0;
                err_cnt_d   = 8'd0;
                underflow_d = 1'b0;
            end else begin
                if (req_fire) begin
                    issue_cnt_d = issue_cnt_q + 10'd1;
                end
                if (retire_dec && vld_hash_err && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                if (retire && (outstanding_q == 7'd0)) begin
                    underflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            next_id_q     <= 6'd0;
            cur_id_q      <= 6'd0;
            cur_last_q    <= 1'b0;
            outstanding_q <= 7'd0;
            pid_done_q    <= 1'b0;
            buf_done_q    <= 1'b0;
            issue_cnt_q   <= 10'd0;
            err_cnt_q     <= 8'd0;
            underflow_q   <= 1'b0;
        end else if (sync_rst) begin
            state_q       <= IDLE;
            next_id_q     <= 6'd0;
            cur_id_q      <= 6'd0;
            cur_last_q    <= 1'b0;
            outstanding_q <= 7'd0;
            pid_done_q    <= 1'b0;
            buf_done_q    <= 1'b0;
            issue_cnt_q   <= 10'd0;
            err_cnt_q     <= 8'd0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_id_q     <= next_id_d;
            cur_id_q      <= cur_id_d;
            cur_last_q    <= cur_last_d;
            outstanding_q <= outstanding_d;
            pid_done_q    <= pid_done_d;
            buf_done_q    <= buf_done_d;
            issue_cnt_q   <= issue_cnt_d;
            err_cnt_q     <= err_cnt_d;
            underflow_q   <= underflow_d;
        end
    end

    assign status_outstanding = outstanding_q;
    assign status_issue_count = issue_cnt_q;
    assign status_err_count   = err_cnt_q;
    assign status_underflow   = underflow_q;

endmodule

// File: doc/sha256_id_issuer.md
# sha256_id_issuer

- Sequencing controller in front of `sha256_id_validator`.
- Per packet:
  - Accepts a packet-start request from the message builder.
  - Allocates the next 6-bit packet ID (modulo 64).
  - Forks that ID to two places: the hash datapath (`pkt_id` channel) and the validator's ID buffer FIFO (`id_buf_out` channel).
- Limits in-flight packets to `MAX_OUTSTANDING`.
- Retires a packet by snooping the validator's hash-out handshake.

## Interface
**Parameters**
- `MAX_OUTSTANDING`, default 16: maximum in-flight packets. Legal range 1..63.

**Ports**

Clock and control:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `en` in 1: enable. When low, all state freezes and all readies are low.
- `sync_rst` in 1: synchronous local reset. Same effect as `rst`, applied at the clock edge.

Seed load:
- `cfg_seed` in 6: ID seed.
- `cfg_seed_valid` in 1, `cfg_seed_ready` out 1: seed handshake.

Packet request (from message builder):
- `pkt_req_last` in 1: request is the final packet of a message.
- `pkt_req_valid` in 1, `pkt_req_ready` out 1: request handshake.

ID to hash datapath:
- `pkt_id` out 6: allocated ID.
- `pkt_id_valid` out 1, `pkt_id_ready` in 1: handshake.

ID to validator ID buffer:
- `id_buf_out` out 6: same allocated ID.
- `id_buf_out_last` out 1: copy of `pkt_req_last`.
- `id_buf_out_valid` out 1, `id_buf_out_ready` in 1: handshake.

Validator hash-out snoop:
- `vld_hash_valid` in 1, `vld_hash_ready` in 1: snoop of the validator hash-out handshake.
- `vld_hash_err` in 1: error flag on that handshake.

Status:
- `status_outstanding` out 7: current in-flight count.
- `status_issue_count` out 10: packets issued.
- `status_err_count` out 8: retired packets with error.
- `status_underflow` out 1: sticky, retire seen with nothing outstanding.
- `status_clear` in 1: clears status counters and sticky bits.

## Operation
**Registers:** `next_id`(6), `cur_id`(6), `cur_last`, `outstanding`(7), `pid_done`, `buf_done`, `state` ∈ {IDLE, ISSUE}.

**Ready equations**
- `cfg_seed_ready` = `en` & IDLE & (`outstanding`==0).
- `pkt_req_ready` = `en` & IDLE & (`outstanding` < `MAX_OUTSTANDING`) & !`cfg_seed_valid`.
- Seed load has priority over a request in the same cycle.

**IDLE state**
- Seed handshake: `next_id` ← `cfg_seed`. State stays IDLE.
- Request handshake:
  - `cur_id` ← `next_id`, `cur_last` ← `pkt_req_last`.
  - `next_id` ← `next_id`+1 mod 64 (63 wraps to 0).
  - `outstanding` += 1.
  - `status_issue_count` += 1, wrapping at 1024.
  - `pid_done`, `buf_done` ← 0; go to ISSUE.

**ISSUE state**
- Outputs:
  - `pkt_id_valid` = !`pid_done`.
  - `id_buf_out_valid` = !`buf_done`.
  - `pkt_id` = `id_buf_out` = `cur_id`; `id_buf_out_last` = `cur_last`.
- Each channel sets its done flag on its own handshake. The two channels complete independently, in any order or in the same cycle.
- Once both done flags are (or become) set, return to IDLE.
- A valid, once raised, is held until its handshake. The ID is stable while valid is high.

**Retire (any state, `en` high)**
- Retire event = `vld_hash_valid` & `vld_hash_ready`.
- If `outstanding`>0: `outstanding` −= 1. If `vld_hash_err`, `status_err_count` += 1, saturating at 255.
- If `outstanding`==0: no decrement; set `status_underflow`.
- Request accept and retire in the same cycle: `outstanding` unchanged.

**Status clear**
- `status_clear` zeroes `status_issue_count`, `status_err_count` and `status_underflow`.
- It does not affect `outstanding`, `next_id` or `state`.
- If clear coincides with an increment event, clear wins.

**Enable**
- `en` low: no register updates, snoop events are ignored, and readies are low.
- Raised valids stay high.

## Timing
- **Reset** (`rst` or `sync_rst`): state IDLE; `next_id`, `cur_id`, `outstanding` = 0; all valids 0; all status outputs 0.
- **Reset mid-ISSUE:** the pending ID is abandoned and valids drop immediately.
- **Latency:** request accepted at cycle N → both valids high at N+1.
  - Both handshaking at N+1 → IDLE at N+2, `pkt_req_ready` may be high at N+2.
- **Peak throughput:** one packet per 2 cycles.
- **Readies** are combinational from registered state plus `cfg_seed_valid`. Valids and data are registered.
- **Status outputs** are registered and update the cycle after the event.
- **Credit full:** with `outstanding`==`MAX_OUTSTANDING`, `pkt_req_ready`=0. A retire at cycle N → `pkt_req_ready`=1 at N+1.

## Test plan
1. **Reset, seed, single packet:** reset, seed 0x3E, issue 3 packets, hold both readies high.
   - IDs 0x3E, 0x3F, 0x00 on both channels.
   - `status_issue_count`=3, `outstanding`=3.
2. **Fork skew:** hold `id_buf_out_ready` low for 5 cycles, `pkt_id_ready` high.
   - `pkt_id` handshakes at N+1; `id_buf_out_valid` stays high with a stable ID.
   - Next `pkt_req_ready` only after `id_buf_out` handshakes.
3. **Credit limit:** `MAX_OUTSTANDING`=4, 6 back-to-back requests, no retires.
   - Exactly 4 accepted; `pkt_req_ready`=0.
   - One retire → 5th request accepted the following cycle.
4. **Retire accounting:** 2 retires with `vld_hash_err`=1,0, then a retire at `outstanding`=0.
   - `status_err_count`=1, `status_underflow`=1.
   - `status_clear` → both 0, `outstanding` unchanged.
5. **Simultaneous events:**
   - `cfg_seed_valid` and `pkt_req_valid` both high at `outstanding`=0: seed loads, request waits.
   - Request accept and retire in the same cycle: `outstanding` unchanged.
6. **Enable/reset mid-flight:**
   - `en` low during ISSUE: valids held, no handshake completes, counters frozen.
   - `sync_rst` pulse during ISSUE: all outputs return to reset values the next cycle.
